// File: rtl/aes_128_inv_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, with the key schedule
// run forward to rk10 and then unwound back to rk0 alongside the rounds.
module aes_128_inv_iter #(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_bus,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_bus
);

  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_DEC, S_DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0 naturally).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [7:0] f_rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] kr_q, kr_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rcnt_q, rcnt_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] out_bus_q, out_bus_d;
  logic         cache_valid_q, cache_valid_d;
  logic [127:0] cached_key_q, cached_key_d;
  logic [127:0] cached_rk10_q, cached_rk10_d;

  // Byte n of the state lives at bits [127-8n -: 8], n = row + 4*column.
  logic [127:0] isr_sub;
  logic [127:0] round_x;
  logic [127:0] round_mc;

  for (genvar gi = 0; gi < 16; gi++) begin : g_isb
    localparam int R   = gi % 4;
    localparam int C   = gi / 4;
    localparam int SRC = R + 4 * ((C + 4 - R) % 4);
    assign isr_sub[127-8*gi -: 8] = inv_sbox(st_q[127-8*SRC -: 8]);
  end

  assign round_x = isr_sub ^ kr_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_imc
    assign round_mc[127-32*gi -: 32] = inv_mix_col(round_x[127-32*gi -: 32]);
  end

  // Key path: one SubWord(RotWord()) shared by forward and inverse expansion.
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_in, rot_w, sub_out, tmix;
  logic [3:0]   rcon_idx;
  logic [127:0] kr_fwd, kr_inv;
  logic [31:0]  n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = kr_q;
  assign sub_in   = (state_q == S_DEC) ? (w3 ^ w2) : w3;
  assign rot_w    = {sub_in[23:0], sub_in[31:24]};
  assign rcon_idx = (state_q == S_DEC) ? (rcnt_q - 4'd1) : rcnt_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ksb
    assign sub_out[31-8*gi -: 8] = sbox(rot_w[31-8*gi -: 8]);
  end

  assign tmix   = sub_out ^ {f_rcon(rcon_idx), 24'h000000};
  assign n0     = w0 ^ tmix;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;
  assign kr_fwd = {n0, n1, n2, n3};
  assign kr_inv = {w0 ^ tmix, w1 ^ w0, w2 ^ w1, w3 ^ w2};

  always_comb begin
    state_d       = state_q;
    st_d          = st_q;
    kr_d          = kr_q;
    key_d         = key_q;
    rcnt_d        = rcnt_q;
    out_valid_d   = out_valid_q;
    out_bus_d     = out_bus_q;
    cache_valid_d = cache_valid_q;
    cached_key_d  = cached_key_q;
    cached_rk10_d = cached_rk10_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          st_d  = in_bus;
          key_d = key;
          if (KEY_CACHE && cache_valid_q && (key == cached_key_q)) begin
            kr_d    = cached_rk10_q;
            rcnt_d  = 4'd10;
            state_d = S_DEC;
          end else begin
            kr_d    = key;
            rcnt_d  = 4'd0;
            state_d = S_KEXP;
          end
        end
      end
      S_KEXP: begin
        kr_d = kr_fwd;
        if (rcnt_q == 4'd9) begin
          rcnt_d  = 4'd10;
          state_d = S_DEC;
          if (KEY_CACHE) begin
            cached_key_d  = key_q;
            cached_rk10_d = kr_fwd;
            cache_valid_d = 1'b1;
          end
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      S_DEC: begin
        kr_d = kr_inv;
        if (rcnt_q == 4'd10) begin
          st_d = st_q ^ kr_q;
        end else if (rcnt_q == 4'd0) begin
          st_d = round_x;
        end else begin
          st_d = round_mc;
        end
        if (rcnt_q == 4'd0) begin
          out_bus_d   = round_x;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      st_q          <= '0;
      kr_q          <= '0;
      key_q         <= '0;
      rcnt_q        <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_bus_q     <= '0;
      cache_valid_q <= 1'b0;
      cached_key_q  <= '0;
      cached_rk10_q <= '0;
    end else begin
      state_q       <= state_d;
      st_q          <= st_d;
      kr_q          <= kr_d;
      key_q         <= key_d;
      rcnt_q        <= rcnt_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_bus_q     <= out_bus_d;
      cache_valid_q <= cache_valid_d;
      cached_key_q  <= cached_key_d;
      cached_rk10_q <= cached_rk10_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bus   = out_bus_q;

endmodule

// File: tb/tb_aes_128_inv_iter.sv
// Scoreboard bench for aes_128_inv_iter: plaintexts are encrypted by a reference
// AES-128 encryptor here, the ciphertext is fed to the decryptor and checked.
module tb_aes_128_inv_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_bus;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_bus;

  logic         in0_valid;
  logic         in0_ready;
  logic [127:0] in0_bus;
  logic [127:0] key0;
  logic         out0_valid;
  logic         out0_ready;
  logic [127:0] out0_bus;

  logic or_manual;
  logic rr_mode;
  logic rr_bit;
  int   cyc;
  int   total;
  int   bad;

  assign out_ready  = rr_mode ? rr_bit : or_manual;
  assign out0_ready = 1'b1;

  aes_128_inv_iter #(.KEY_CACHE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bus(in_bus), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .out_bus(out_bus)
  );

  aes_128_inv_iter #(.KEY_CACHE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in0_valid), .in_ready(in0_ready),
    .in_bus(in0_bus), .key(key0), .out_valid(out0_valid), .out_ready(out0_ready),
    .out_bus(out0_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) rr_bit = ($urandom_range(0, 3) != 0);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, cst;
    cst = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 0;
      for (int b = 1; b < 256; b++)
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sbox_t[a] = s;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r+4*c] = sbox_t[s[r+4*((c+r)%4)]];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = t[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sb [$];
  exp_t         cur;
  logic         mon_busy;
  logic         mc_valid;
  logic [127:0] mc_key;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy = 1'b0;
    end else if (out_valid) begin
      if (!mon_busy) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output actual=%h required=no output", out_bus);
        end else begin
          cur = sb.pop_front();
          chk("plaintext", out_bus, cur.pt);
          chk("latency", 128'(cyc - cur.acc), 128'(cur.lat));
          $display("block: pt=%h latency=%0d (required %0d)", out_bus, cyc - cur.acc, cur.lat);
        end
        mon_busy = 1'b1;
      end else begin
        chk("out_hold", out_bus, cur.pt);
      end
    end else begin
      mon_busy = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [127:0] ct, input logic [127:0] k,
                      input logic [127:0] pt, input bit push);
    int   n;
    exp_t e;
    n        = 0;
    in_bus   = ct;
    key      = k;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 128'(in_ready), 128'(1));
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_bus   = {$urandom, $urandom, $urandom, $urandom};
    key      = {$urandom, $urandom, $urandom, $urandom};
    e.pt  = pt;
    e.acc = cyc;
    e.lat = (mc_valid && k == mc_key) ? 11 : 21;
    if (push) sb.push_back(e);
    mc_valid = 1'b1;
    mc_key   = k;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 128'(sb.size()), 128'(0));
  endtask

  localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    logic [127:0] k, pt, prev_k;
    int           n;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bus    = '0;
    key       = '0;
    in0_valid = 1'b0;
    in0_bus   = '0;
    key0      = '0;
    or_manual = 1'b1;
    rr_mode   = 1'b0;
    mc_valid  = 1'b0;
    mc_key    = '0;
    mon_busy  = 1'b0;
    build_sbox();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_bus", out_bus, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 128'(in_ready), 128'(1));

    send(C1_CT, C1_K, C1_PT, 1);
    send(B_CT, B_K, B_PT, 1);
    repeat (10) @(negedge clk);
    chk("rk10_probe", dut.kr_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    send(B_CT, B_K, B_PT, 1);
    send(C1_CT, C1_K, C1_PT, 1);
    drain();

    // Backpressure: result held, new input refused while downstream stalls.
    or_manual = 1'b0;
    k  = {$urandom, $urandom, $urandom, $urandom};
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(aes_enc(pt, k), k, pt, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 128'(out_valid), 128'(1));
    in_valid = 1'b1;
    in_bus   = {$urandom, $urandom, $urandom, $urandom};
    repeat (15) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_out_valid", 128'(out_valid), 128'(1));
    end
    in_valid  = 1'b0;
    or_manual = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", 128'(out_valid), 128'(0));
    chk("bp_released_ready", 128'(in_ready), 128'(1));

    // Reset in the middle of decryption; the cache must be forgotten.
    k  = {$urandom, $urandom, $urandom, $urandom};
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(aes_enc(pt, k), k, pt, 0);
    repeat (15) @(negedge clk);
    chk("mid_dec_rcnt", 128'(dut.rcnt_q), 128'(5));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_out_bus", out_bus, 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    mc_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", 128'(in_ready), 128'(1));
    send(aes_enc(pt, k), k, pt, 1);
    drain();

    // Random round-trips with frequent key reuse and random backpressure.
    rr_mode = 1'b1;
    prev_k  = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 24; i++) begin
      k  = ($urandom_range(0, 1) == 1) ? prev_k : {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(aes_enc(pt, k), k, pt, 1);
      prev_k = k;
    end
    drain();
    rr_mode = 1'b0;

    // Without the cache every block pays the full expansion.
    for (int i = 0; i < 2; i++) begin
      in0_bus   = B_CT;
      key0      = B_K;
      in0_valid = 1'b1;
      n = 0;
      while (!in0_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      in0_valid = 1'b0;
      n = 0;
      while (!out0_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("nocache_latency", 128'(n), 128'(21));
      chk("nocache_plaintext", out0_bus, B_PT);
      $display("nocache block %0d: pt=%h latency=%0d", i, out0_bus, n);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
